// File: rtl/jtag_dr_tx.sv
// Transmit side of the JTAG user data registers: presents a soc-written word on
// JTDO1 (ER1) or JTDO2 (ER2), captured and shifted LSB first under the host's TCK.
module jtag_dr_tx #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TCK_SYNC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtck,
  input  logic             jshift,
  input  logic             jce1,
  input  logic             jce2,
  input  logic             jrstn,
  output logic             jtdo1,
  output logic             jtdo2,
  input  logic [WIDTH-1:0] tx_data0,
  input  logic             tx_we0,
  input  logic [WIDTH-1:0] tx_data1,
  input  logic             tx_we1,
  output logic [1:0]       tx_pending,
  output logic             captured
);

  localparam int unsigned NEW = TCK_SYNC - 2;
  localparam int unsigned OLD = TCK_SYNC - 1;

  logic [TCK_SYNC-1:0] jtck_sync_q,   jtck_sync_d;
  logic [TCK_SYNC-1:0] jshift_sync_q, jshift_sync_d;
  logic [TCK_SYNC-1:0] jce1_sync_q,   jce1_sync_d;
  logic [TCK_SYNC-1:0] jce2_sync_q,   jce2_sync_d;
  logic [TCK_SYNC-1:0] jrstn_sync_q,  jrstn_sync_d;

  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] hold1_q, hold1_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [1:0]       pending_q, pending_d;
  logic             captured_q, captured_d;
  logic             sel_q, sel_d;
  logic             shift_due_q, shift_due_d;
  logic             jtdo1_q, jtdo1_d;
  logic             jtdo2_q, jtdo2_d;

  logic tck_rise_c, tck_fall_c;
  logic shift_c, ce1_c, ce2_c, tap_rst_c;
  logic sel_ch_c;

  // Synchroniser chains: new samples enter at bit 0 and move toward bit OLD
  always_comb begin
    jtck_sync_d   = {jtck_sync_q[TCK_SYNC-2:0],   jtck};
    jshift_sync_d = {jshift_sync_q[TCK_SYNC-2:0], jshift};
    jce1_sync_d   = {jce1_sync_q[TCK_SYNC-2:0],   jce1};
    jce2_sync_d   = {jce2_sync_q[TCK_SYNC-2:0],   jce2};
    jrstn_sync_d  = {jrstn_sync_q[TCK_SYNC-2:0],  jrstn};
  end

  // Controls come from the last stage: the values held just before the TCK edge seen at NEW
  always_comb begin
    tck_rise_c = jtck_sync_q[NEW] & ~jtck_sync_q[OLD];
    tck_fall_c = ~jtck_sync_q[NEW] & jtck_sync_q[OLD];
    shift_c    = jshift_sync_q[OLD];
    ce1_c      = jce1_sync_q[OLD];
    ce2_c      = jce2_sync_q[OLD];
    tap_rst_c  = ~jrstn_sync_q[OLD];
    sel_ch_c   = ce2_c;
  end

  // Hold registers, capture, shift and TDO next-state
  always_comb begin
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    sr_d        = sr_q;
    pending_d   = pending_q;
    captured_d  = 1'b0;
    sel_d       = sel_q;
    shift_due_d = shift_due_q;
    jtdo1_d     = 1'b0;
    jtdo2_d     = 1'b0;

    if (tx_we0) hold0_d = tx_data0;
    if (tx_we1) hold1_d = tx_data1;

    // Capture-DR reads the hold value from before any same-cycle write
    if (tck_rise_c && (ce1_c || ce2_c) && !shift_c) begin
      sel_d               = sel_ch_c;
      sr_d                = sel_ch_c ? hold1_q : hold0_q;
      pending_d[sel_ch_c] = 1'b0;
      captured_d          = pending_q[sel_ch_c];
    end

    if (tck_rise_c && (ce1_c || ce2_c) && shift_c) shift_due_d = 1'b1;

    if (tck_fall_c && shift_due_q) begin
      sr_d        = {1'b0, sr_q[WIDTH-1:1]};
      shift_due_d = 1'b0;
    end

    // A write in the capture cycle leaves the word pending for the next capture
    if (tx_we0) pending_d[0] = 1'b1;
    if (tx_we1) pending_d[1] = 1'b1;

    if (tap_rst_c) begin
      hold0_d     = '0;
      hold1_d     = '0;
      sr_d        = '0;
      pending_d   = '0;
      captured_d  = 1'b0;
      sel_d       = 1'b0;
      shift_due_d = 1'b0;
    end

    jtdo1_d = ~sel_d & sr_d[0];
    jtdo2_d = sel_d & sr_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jtck_sync_q   <= '0;
      jshift_sync_q <= '0;
      jce1_sync_q   <= '0;
      jce2_sync_q   <= '0;
      jrstn_sync_q  <= '1;
      hold0_q       <= '0;
      hold1_q       <= '0;
      sr_q          <= '0;
      pending_q     <= '0;
      captured_q    <= 1'b0;
      sel_q         <= 1'b0;
      shift_due_q   <= 1'b0;
      jtdo1_q       <= 1'b0;
      jtdo2_q       <= 1'b0;
    end else begin
      jtck_sync_q   <= jtck_sync_d;
      jshift_sync_q <= jshift_sync_d;
      jce1_sync_q   <= jce1_sync_d;
      jce2_sync_q   <= jce2_sync_d;
      jrstn_sync_q  <= jrstn_sync_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      sr_q          <= sr_d;
      pending_q     <= pending_d;
      captured_q    <= captured_d;
      sel_q         <= sel_d;
      shift_due_q   <= shift_due_d;
      jtdo1_q       <= jtdo1_d;
      jtdo2_q       <= jtdo2_d;
    end
  end

  assign jtdo1      = jtdo1_q;
  assign jtdo2      = jtdo2_q;
  assign tx_pending = pending_q;
  assign captured   = captured_q;

endmodule

// File: tb/tb_jtag_dr_tx.sv
// Directed bench for jtag_dr_tx: a host model drives TCK/JCE/JSHIFT and compares
// the scanned-out words against a queue of expected words.
module tb_jtag_dr_tx;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned TCK_SYNC = 3;
  localparam int          HALF     = 12;  // clk cycles per TCK phase
  localparam int          QTR      = 4;   // clk cycles after TCK rise when TAP outputs change

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             jtck = 1'b0;
  logic             jshift = 1'b0;
  logic             jce1 = 1'b0;
  logic             jce2 = 1'b0;
  logic             jrstn = 1'b1;
  logic             jtdo1;
  logic             jtdo2;
  logic [WIDTH-1:0] tx_data0 = '0;
  logic             tx_we0 = 1'b0;
  logic [WIDTH-1:0] tx_data1 = '0;
  logic             tx_we1 = 1'b0;
  logic [1:0]       tx_pending;
  logic             captured;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cap_cnt  = 0;
  logic [63:0] exp_q[$];

  jtag_dr_tx #(.WIDTH(WIDTH), .TCK_SYNC(TCK_SYNC)) dut (
    .clk(clk), .rst(rst), .jtck(jtck), .jshift(jshift), .jce1(jce1), .jce2(jce2),
    .jrstn(jrstn), .jtdo1(jtdo1), .jtdo2(jtdo2), .tx_data0(tx_data0), .tx_we0(tx_we0),
    .tx_data1(tx_data1), .tx_we1(tx_we1), .tx_pending(tx_pending), .captured(captured)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (captured === 1'b1) cap_cnt <= cap_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input bit ch, input logic [WIDTH-1:0] d);
    @(negedge clk);
    if (ch) begin tx_data1 = d; tx_we1 = 1'b1; end
    else    begin tx_data0 = d; tx_we0 = 1'b1; end
    @(negedge clk);
    tx_we0 = 1'b0;
    tx_we1 = 1'b0;
  endtask

  // TCK high phase; optionally strobes tx_we0 in exactly the clk that sees the rise
  task automatic tck_high(input bit last, input bit wr_cap, input logic [WIDTH-1:0] wr_val);
    jtck = 1'b1;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clk);
      if (wr_cap && k == int'(TCK_SYNC) - 1) begin tx_data0 = wr_val; tx_we0 = 1'b1; end
      if (wr_cap && k == int'(TCK_SYNC)) tx_we0 = 1'b0;
      if (k == QTR) begin
        if (last) begin jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0; end
        else jshift = 1'b1;
      end
    end
    jtck = 1'b0;
  endtask

  // ch: 0 = ER1, 1 = ER2, 2 = both JCE lines high (reads jtdo2)
  task automatic dr_scan(input int ch, input int nbits, input bit wr_cap,
                         input logic [WIDTH-1:0] wr_val, input int rst_at, input int jrst_at,
                         output logic [63:0] bits, output bit other_hi);
    bits = '0;
    other_hi = 1'b0;
    jce1 = (ch != 1);
    jce2 = (ch != 0);
    jshift = 1'b0;
    repeat (HALF) @(negedge clk);
    tck_high(1'b0, wr_cap, wr_val);
    for (int i = 0; i < nbits; i++) begin
      if (i == jrst_at) begin
        jrstn = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0;
        repeat (2) begin
          repeat (HALF) @(negedge clk);
          jtck = 1'b1;
          repeat (HALF) @(negedge clk);
          jtck = 1'b0;
        end
        jrstn = 1'b1;
        repeat (HALF) @(negedge clk);
        check("jrst_jtdo", 64'({jtdo1, jtdo2}), 64'd0);
        check("jrst_pending", 64'(tx_pending), 64'd0);
        return;
      end
      if (i == rst_at) begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_jtdo1", 64'(jtdo1), 64'd0);
        check("rst_pending", 64'(tx_pending), 64'd0);
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bits[i] = (ch == 0) ? jtdo1 : jtdo2;
      other_hi = other_hi | ((ch == 0) ? jtdo2 : jtdo1);
      tck_high(i == nbits - 1, 1'b0, '0);
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic scan_check(input string tag, input int ch, input int nbits,
                            input logic [63:0] expected, input int exp_cap,
                            input logic [1:0] exp_pend, input bit wr_cap,
                            input logic [WIDTH-1:0] wr_val, input int rst_at, input int jrst_at);
    logic [63:0] bits;
    logic [63:0] e;
    bit          other_hi;
    int          c0;
    exp_q.push_back(expected);
    c0 = cap_cnt;
    dr_scan(ch, nbits, wr_cap, wr_val, rst_at, jrst_at, bits, other_hi);
    e = exp_q.pop_front();
    check({tag, "_word"}, bits, e);
    check({tag, "_other_tdo"}, 64'(other_hi), 64'd0);
    check({tag, "_captured"}, 64'(cap_cnt - c0), 64'(exp_cap));
    check({tag, "_pending"}, 64'(tx_pending), 64'(exp_pend));
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_jtdo", 64'({jtdo1, jtdo2}), 64'd0);
    check("reset_pending", 64'(tx_pending), 64'd0);
    check("reset_captured", 64'(captured), 64'd0);

    host_write(1'b0, 32'hDEADBEEF);
    check("wr0_pending", 64'(tx_pending), 64'd1);
    scan_check("er1", 0, 32, 64'hDEADBEEF, 1, 2'b00, 1'b0, '0, -1, -1);

    host_write(1'b1, 32'h12345678);
    check("wr1_pending", 64'(tx_pending), 64'd2);
    scan_check("er2", 1, 32, 64'h12345678, 1, 2'b00, 1'b0, '0, -1, -1);
    scan_check("er2_again", 1, 32, 64'h12345678, 0, 2'b00, 1'b0, '0, -1, -1);

    host_write(1'b0, 32'hFFFFFFFF);
    scan_check("over40", 0, 40, 64'h00000000FFFFFFFF, 1, 2'b00, 1'b0, '0, -1, -1);

    host_write(1'b1, 32'h0BADF00D);
    host_write(1'b0, 32'h600DCAFE);
    check("both_pending", 64'(tx_pending), 64'd3);
    scan_check("er2_wins", 2, 32, 64'h0BADF00D, 1, 2'b01, 1'b0, '0, -1, -1);

    host_write(1'b0, 32'h11111111);
    scan_check("wr_cap", 0, 32, 64'h11111111, 1, 2'b01, 1'b1, 32'hA5A5A5A5, -1, -1);
    scan_check("wr_cap_next", 0, 32, 64'hA5A5A5A5, 1, 2'b00, 1'b0, '0, -1, -1);

    host_write(1'b1, 32'h00000077);
    host_write(1'b0, 32'hCAFEF00D);
    scan_check("rst_mid", 0, 32, 64'h000000000000000D, 1, 2'b00, 1'b0, '0, 10, -1);

    host_write(1'b0, 32'h0F0F0F0F);
    host_write(1'b1, 32'h3C3C3C3C);
    scan_check("jrst_mid", 0, 32, 64'h0000000000000F0F, 1, 2'b00, 1'b0, '0, -1, 12);
    scan_check("jrst_stale", 1, 32, 64'h0, 0, 2'b00, 1'b0, '0, -1, -1);
    host_write(1'b0, 32'h5A5AC3C3);
    scan_check("jrst_fresh", 0, 32, 64'h5A5AC3C3, 1, 2'b00, 1'b0, '0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
